// File: rtl/hms_time_core_if.sv
// rtl/hms_time_core_if.sv - switch inputs and time display outputs of the h:m:s core
// Purpose: bundles the raw front-panel switches and the binary time fields.
// Signals:
//   i_sw_mode, i_sw_pos, i_sw_inc  raw active-low switches (pressed = 0)
//   o_mode                         0 = CLOCK, 1 = SETUP
//   o_pos                          edited field: 0 = SEC, 1 = MIN, 2 = HOUR
//   o_sec, o_min, o_hour           binary time fields
//   o_sec_tick, o_day_tick         1-clk update pulses
// Modports: master = timekeeping core, slave = switch driver / display consumer.
interface hms_time_core_if;
    logic       i_sw_mode;
    logic       i_sw_pos;
    logic       i_sw_inc;
    logic       o_mode;
    logic [1:0] o_pos;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_sec_tick;
    logic       o_day_tick;

    modport master (
        input  i_sw_mode, i_sw_pos, i_sw_inc,
        output o_mode, o_pos, o_sec, o_min, o_hour, o_sec_tick, o_day_tick
    );

    modport slave (
        output i_sw_mode, i_sw_pos, i_sw_inc,
        input  o_mode, o_pos, o_sec, o_min, o_hour, o_sec_tick, o_day_tick
    );
endinterface

// File: rtl/hms_time_core.sv
// rtl/hms_time_core.sv - single-clock hour:minute:second core with prescaler and debounce
// Purpose: keeps time from a clk prescaler, debounces three switches and provides a
//   CLOCK/SETUP mode controller with SEC/MIN/HOUR field editing. All state is on clk;
//   second ticks and switch presses act as enables.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    hms_time_core_if.master (raw switches in, mode/pos/fields/ticks out)
// Parameters:
//   TICK_DIV  clk cycles per second tick (>= 2)
//   DEB_DIV   clk cycles per switch sample period (>= 1)
//   HOUR_MAX  last hour value before wrap (<= 31)
module hms_time_core #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DEB_DIV  = 500_000,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    hms_time_core_if.master bus
);

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] DEB_LAST  = 32'(DEB_DIV - 1);
    localparam logic [4:0]  HOUR_LAST = 5'(HOUR_MAX);

    // Switch index order in the vectors below: 0 = mode, 1 = pos, 2 = inc.
    logic [2:0]      sw_raw;
    logic [2:0]      sw_meta;
    logic [2:0]      sw_sync;
    logic [2:0][2:0] hist;
    logic [2:0]      press;
    logic [31:0]     deb_cnt;
    logic            sample_en;

    logic            mode_ev;
    logic            pos_ev;
    logic            inc_ev;

    mode_t           mode_r;
    mode_t           mode_nxt;
    pos_t            pos_r;
    pos_t            pos_nxt;

    logic [31:0]     pre_cnt;
    logic            tick;

    logic [5:0]      sec_r, sec_nxt;
    logic [5:0]      min_r, min_nxt;
    logic [4:0]      hour_r, hour_nxt;
    logic            sec_tick_r, sec_tick_nxt;
    logic            day_tick_r, day_tick_nxt;

    assign sw_raw    = {bus.i_sw_inc, bus.i_sw_pos, bus.i_sw_mode};
    assign sample_en = (deb_cnt == DEB_LAST);

    // Two-flop synchroniser on the raw switches, then a 3-sample history shifted
    // once per sample period. All three switches share one sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            sw_meta <= '1;
            sw_sync <= '1;
            hist    <= '1;
        end else begin
            deb_cnt <= sample_en ? '0 : deb_cnt + 32'd1;
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
            if (sample_en) begin
                for (int i = 0; i < 3; i++) begin
                    hist[i] <= {hist[i][1:0], sw_sync[i]};
                end
            end
        end
    end

    // A press fires on the sample edge where the history becomes 3'b100: one
    // released sample followed by two low samples. A one-sample glitch never
    // reaches that pattern and a held switch only passes through it once.
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = sample_en && (hist[i][1:0] == 2'b10) && !sw_sync[i];
        end
    end

    assign mode_ev = press[0];
    assign pos_ev  = press[1];
    assign inc_ev  = press[2];

    // Mode / position state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_CLOCK;
            pos_r  <= POS_SEC;
        end else begin
            mode_r <= mode_nxt;
            pos_r  <= pos_nxt;
        end
    end

    always_comb begin
        mode_nxt = mode_r;
        pos_nxt  = pos_r;
        if (mode_ev) begin
            mode_nxt = (mode_r == MODE_CLOCK) ? MODE_SETUP : MODE_CLOCK;
        end
        if (pos_ev) begin
            case (pos_r)
                POS_SEC: pos_nxt = POS_MIN;
                POS_MIN: pos_nxt = POS_HOUR;
                default: pos_nxt = POS_SEC;
            endcase
        end
    end

    // Prescaler only runs while staying in CLOCK, so it sits at 0 throughout
    // SETUP and every return to CLOCK starts a fresh second.
    assign tick = (mode_r == MODE_CLOCK) && (pre_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (mode_r == MODE_CLOCK && mode_nxt == MODE_CLOCK) begin
            pre_cnt <= tick ? '0 : pre_cnt + 32'd1;
        end else begin
            pre_cnt <= '0;
        end
    end

    // Field update. The current mode register picks between tick-driven counting
    // and editing, so a simultaneous mode press only affects later cycles; edits
    // use the current position for the same reason.
    always_comb begin
        sec_nxt      = sec_r;
        min_nxt      = min_r;
        hour_nxt     = hour_r;
        sec_tick_nxt = 1'b0;
        day_tick_nxt = 1'b0;
        if (mode_r == MODE_CLOCK) begin
            if (tick) begin
                sec_tick_nxt = 1'b1;
                if (sec_r == 6'd59) begin
                    sec_nxt = 6'd0;
                    if (min_r == 6'd59) begin
                        min_nxt = 6'd0;
                        if (hour_r == HOUR_LAST) begin
                            hour_nxt     = 5'd0;
                            day_tick_nxt = 1'b1;
                        end else begin
                            hour_nxt = hour_r + 5'd1;
                        end
                    end else begin
                        min_nxt = min_r + 6'd1;
                    end
                end else begin
                    sec_nxt = sec_r + 6'd1;
                end
            end
        end else if (inc_ev) begin
            case (pos_r)
                POS_SEC:  sec_nxt  = (sec_r == 6'd59)     ? 6'd0 : sec_r + 6'd1;
                POS_MIN:  min_nxt  = (min_r == 6'd59)     ? 6'd0 : min_r + 6'd1;
                default:  hour_nxt = (hour_r == HOUR_LAST) ? 5'd0 : hour_r + 5'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_r      <= '0;
            min_r      <= '0;
            hour_r     <= '0;
            sec_tick_r <= 1'b0;
            day_tick_r <= 1'b0;
        end else begin
            sec_r      <= sec_nxt;
            min_r      <= min_nxt;
            hour_r     <= hour_nxt;
            sec_tick_r <= sec_tick_nxt;
            day_tick_r <= day_tick_nxt;
        end
    end

    assign bus.o_mode     = mode_r;
    assign bus.o_pos      = pos_r;
    assign bus.o_sec      = sec_r;
    assign bus.o_min      = min_r;
    assign bus.o_hour     = hour_r;
    assign bus.o_sec_tick = sec_tick_r;
    assign bus.o_day_tick = day_tick_r;

endmodule
